// File: rtl/sram_port1_reader.sv
// sram_port1_reader
// Reads a contiguous run of words from SRAM read port 1 and presents them as a
// valid/ready stream. Each word is tagged with its SRAM address, and the final
// word of the run is marked. A 2-entry skid FIFO absorbs the one-cycle SRAM
// read latency, so the block sustains one word per cycle when the consumer is
// always ready.
//
// Ports
//   wb_clk_i   : clock, shared with SRAM clk1
//   wb_rst_i   : synchronous active-high reset
//   start      : one-cycle command strobe; base_addr/length sampled with it
//   base_addr  : first word address
//   length     : word count, 0..2^ADDR_W
//   abort      : cancel the active transfer
//   busy       : transfer in progress (RUN or DRAIN)
//   done       : one-cycle completion pulse (normal end, abort, or length 0)
//   csb1/addr1 : SRAM port-1 chip select (active-low) and address
//   dout1      : SRAM port-1 read data, valid the cycle after the read
//   out_*      : output stream (valid/ready, data, address, last)
module sram_port1_reader #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              csb1,
   output logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] dout1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0]  remaining_q;
   logic              done_q;

   // Read issued last cycle; its data is on dout1 this cycle
   logic              infl_q;
   logic [ADDR_W-1:0] infl_addr_q;
   logic              infl_last_q;

   logic [DATA_W-1:0] fifo_data_q [DEPTH];
   logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
   logic [DEPTH-1:0]  fifo_last_q;
   logic              wr_idx_q;
   logic              rd_idx_q;
   logic [1:0]        count_q;

   logic              pop_c;
   logic              issue_c;
   logic [2:0]        commit_c;

   // Issue decision: never commit more words than the FIFO can hold.
   // csb1 must react to abort in the same cycle, so this stays combinational.
   always_comb begin
      pop_c    = (count_q != 2'd0) && out_ready;
      commit_c = 3'(count_q) + 3'(infl_q) - 3'(pop_c);
      issue_c  = (state_q == RUN) && (remaining_q != '0) && !abort &&
                 (commit_c < 3'd2);
   end

   // Control FSM, read pipeline and FIFO
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         rd_ptr_q    <= '0;
         remaining_q <= '0;
         done_q      <= 1'b0;
         infl_q      <= 1'b0;
         infl_addr_q <= '0;
         infl_last_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_addr_q[i] <= '0;
         end
         fifo_last_q <= '0;
         wr_idx_q    <= 1'b0;
         rd_idx_q    <= 1'b0;
         count_q     <= 2'd0;
      end else begin
         done_q <= 1'b0;
         infl_q <= issue_c;

         if (issue_c) begin
            rd_ptr_q    <= rd_ptr_q + ADDR_W'(1);
            remaining_q <= remaining_q - CNT_W'(1);
            infl_addr_q <= rd_ptr_q;
            infl_last_q <= (remaining_q == CNT_W'(1));
         end

         // Capture the word returned for last cycle's read
         if (infl_q) begin
            fifo_data_q[wr_idx_q] <= dout1;
            fifo_addr_q[wr_idx_q] <= infl_addr_q;
            fifo_last_q[wr_idx_q] <= infl_last_q;
            wr_idx_q              <= ~wr_idx_q;
         end
         if (pop_c) begin
            rd_idx_q <= ~rd_idx_q;
         end
         count_q <= count_q + 2'(infl_q) - 2'(pop_c);

         case (state_q)
            IDLE: begin
               if (start) begin
                  if (length == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q     <= RUN;
                     rd_ptr_q    <= base_addr;
                     remaining_q <= length;
                  end
               end
            end
            RUN, DRAIN: begin
               if (abort) begin
                  // Drop the FIFO contents and the word still in flight
                  state_q  <= IDLE;
                  done_q   <= 1'b1;
                  infl_q   <= 1'b0;
                  count_q  <= 2'd0;
                  wr_idx_q <= 1'b0;
                  rd_idx_q <= 1'b0;
               end else if (pop_c && fifo_last_q[rd_idx_q]) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end else if ((state_q == RUN) && issue_c &&
                            (remaining_q == CNT_W'(1))) begin
                  state_q <= DRAIN;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign csb1      = ~issue_c;
   assign addr1     = rd_ptr_q;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = fifo_data_q[rd_idx_q];
   assign out_addr  = fifo_addr_q[rd_idx_q];
   assign out_last  = out_valid && fifo_last_q[rd_idx_q];

endmodule

// File: tb/tb_sram_port1_reader.sv
// Directed bench for sram_port1_reader with a one-cycle-latency SRAM model.
module tb_sram_port1_reader;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic              out_ready;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   length;
   logic              busy, done, csb1, out_valid, out_last;
   logic [ADDR_W-1:0] addr1, out_addr;
   logic [DATA_W-1:0] dout1, out_data;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int busy_cnt    = 0;

   int         rd_cyc[$];
   logic [7:0] rd_addr[$];
   int         hs_cyc[$];
   logic [7:0] hs_addr[$];
   logic [31:0] hs_data[$];
   logic       hs_last[$];
   int         done_cyc[$];

   sram_port1_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .start    (start),
      .base_addr(base_addr),
      .length   (length),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .csb1     (csb1),
      .addr1    (addr1),
      .dout1    (dout1),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_addr (out_addr),
      .out_last (out_last)
   );

   function automatic logic [31:0] data_of(input logic [7:0] a);
      return {8'hC3, a, ~a, a + 8'h11};
   endfunction

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM: address sampled at the edge, data presented for the following cycle
   always @(posedge clk) dout1 <= !csb1 ? data_of(addr1) : 32'hDEAD_BEEF;

   // Event logger
   always @(negedge clk) begin
      if (!csb1) begin
         rd_cyc.push_back(cyc);
         rd_addr.push_back(addr1);
      end
      if (out_valid && out_ready) begin
         hs_cyc.push_back(cyc);
         hs_addr.push_back(out_addr);
         hs_data.push_back(out_data);
         hs_last.push_back(out_last);
      end
      if (done) done_cyc.push_back(cyc);
      if (busy) busy_cnt++;
   end

   task automatic clear_logs();
      rd_cyc.delete(); rd_addr.delete();
      hs_cyc.delete(); hs_addr.delete(); hs_data.delete(); hs_last.delete();
      done_cyc.delete();
      busy_cnt = 0;
   endtask

   task automatic start_xfer(input logic [7:0] b, input logic [8:0] l, output int s);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; length = l; s = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      base_addr = '0; length = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++; if (csb1 !== 1'b1) begin miscompares++; $display("FAIL reset_csb1 got %b want 1", csb1); end
      vectors++; if (addr1 !== 8'h00) begin miscompares++; $display("FAIL reset_addr1 got %h want 00", addr1); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", out_data); end
      vectors++; if (out_addr !== 8'h00) begin miscompares++; $display("FAIL reset_out_addr got %h want 00", out_addr); end
      vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last got %b want 0", out_last); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int s; bit ok;
      clear_logs(); out_ready = 1'b1;
      start_xfer(8'h10, 9'd4, s);
      wait_done(40, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL basic_done_timeout got none want pulse"); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      vectors++; if (rd_addr.size() != 4) begin miscompares++; $display("FAIL basic_read_count got %0d want 4", rd_addr.size()); end
      for (int i = 0; i < rd_addr.size() && i < 4; i++) begin
         vectors++;
         if (rd_addr[i] !== 8'(8'h10 + i) || rd_cyc[i] != s + 1 + i) begin
            miscompares++;
            $display("FAIL basic_read%0d got addr %h cyc %0d want addr %h cyc %0d", i, rd_addr[i], rd_cyc[i], 8'(8'h10 + i), s + 1 + i);
         end
      end
      vectors++; if (hs_addr.size() != 4) begin miscompares++; $display("FAIL basic_word_count got %0d want 4", hs_addr.size()); end
      for (int i = 0; i < hs_addr.size() && i < 4; i++) begin
         vectors++;
         if (hs_addr[i] !== 8'(8'h10 + i) || hs_data[i] !== data_of(8'(8'h10 + i)) ||
             hs_last[i] !== (i == 3) || hs_cyc[i] != s + 3 + i) begin
            miscompares++;
            $display("FAIL basic_word%0d got a=%h d=%h l=%b c=%0d want a=%h d=%h l=%b c=%0d", i, hs_addr[i], hs_data[i], hs_last[i], hs_cyc[i],
                     8'(8'h10 + i), data_of(8'(8'h10 + i)), (i == 3), s + 3 + i);
         end
      end
      vectors++;
      if (done_cyc.size() != 1 || done_cyc[0] != s + 7) begin
         miscompares++;
         $display("FAIL basic_done_cycle got n=%0d c=%0d want n=1 c=%0d", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, s + 7);
      end
   endtask

   task automatic test_wrap();
      int s; bit ok;
      logic [7:0] exp [4];
      exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      clear_logs(); out_ready = 1'b1;
      start_xfer(8'hFE, 9'd4, s);
      wait_done(40, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_done_timeout got none want pulse"); end
      vectors++; if (hs_addr.size() != 4 || rd_addr.size() != 4) begin miscompares++; $display("FAIL wrap_counts got words %0d reads %0d want 4 4", hs_addr.size(), rd_addr.size()); end
      for (int i = 0; i < hs_addr.size() && i < 4; i++) begin
         vectors++;
         if (rd_addr[i] !== exp[i] || hs_addr[i] !== exp[i] || hs_data[i] !== data_of(exp[i]) || hs_last[i] !== (i == 3)) begin
            miscompares++;
            $display("FAIL wrap_word%0d got rd=%h a=%h d=%h l=%b want a=%h d=%h l=%b", i, rd_addr[i], hs_addr[i], hs_data[i], hs_last[i], exp[i], data_of(exp[i]), (i == 3));
         end
      end
   endtask

   task automatic test_stall();
      int s; bit ok; int early;
      clear_logs(); out_ready = 1'b0;
      start_xfer(8'h30, 9'd8, s);
      repeat (2) @(posedge clk);
      // Head word must be presented and held from s+3 through s+10
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); #1;
         vectors++;
         if (out_valid !== 1'b1 || out_addr !== 8'h30 || out_data !== data_of(8'h30) || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold%0d got v=%b a=%h d=%h l=%b want v=1 a=30 d=%h l=0", k, out_valid, out_addr, out_data, out_last, data_of(8'h30));
         end
         @(posedge clk);
      end
      #1;
      early = rd_addr.size();
      out_ready = 1'b1;
      vectors++; if (early != 2) begin miscompares++; $display("FAIL stall_reads_before got %0d want 2", early); end
      wait_done(60, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL stall_done_timeout got none want pulse"); end
      vectors++; if (hs_addr.size() != 8 || rd_addr.size() != 8) begin miscompares++; $display("FAIL stall_counts got words %0d reads %0d want 8 8", hs_addr.size(), rd_addr.size()); end
      for (int i = 0; i < hs_addr.size() && i < 8; i++) begin
         vectors++;
         if (hs_addr[i] !== 8'(8'h30 + i) || hs_data[i] !== data_of(8'(8'h30 + i)) || hs_last[i] !== (i == 7)) begin
            miscompares++;
            $display("FAIL stall_word%0d got a=%h d=%h l=%b want a=%h l=%b", i, hs_addr[i], hs_data[i], hs_last[i], 8'(8'h30 + i), (i == 7));
         end
      end
   endtask

   task automatic test_zero_len();
      int s;
      clear_logs(); out_ready = 1'b1;
      start_xfer(8'h55, 9'd0, s);
      @(negedge clk); #1;
      vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL zero_done_next got done=%b busy=%b want 1 0", done, busy); end
      repeat (5) @(posedge clk);
      @(negedge clk); #1;
      vectors++; if (done_cyc.size() != 1 || done_cyc[0] != s + 1) begin miscompares++; $display("FAIL zero_done_once got n=%0d want 1 at %0d", done_cyc.size(), s + 1); end
      vectors++; if (rd_addr.size() != 0) begin miscompares++; $display("FAIL zero_reads got %0d want 0", rd_addr.size()); end
      vectors++; if (busy_cnt != 0) begin miscompares++; $display("FAIL zero_busy got %0d busy cycles want 0", busy_cnt); end
   endtask

   task automatic test_abort();
      int s, a, late_rd, late_hs; bit ok;
      clear_logs(); out_ready = 1'b1;
      start_xfer(8'h40, 9'd16, s);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (hs_addr.size() >= 3) begin ok = 1'b1; break; end
      end
      vectors++; if (!ok) begin miscompares++; $display("FAIL abort_third_word_timeout got %0d words want 3", hs_addr.size()); end
      @(posedge clk); #1;
      abort = 1'b1; a = cyc;
      @(negedge clk); #1;
      vectors++; if (csb1 !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL abort_cycle got csb1=%b busy=%b want 1 1", csb1, busy); end
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_after got valid=%b done=%b busy=%b want 0 1 0", out_valid, done, busy);
      end
      repeat (4) @(posedge clk);
      @(negedge clk); #1;
      late_rd = 0; late_hs = 0;
      foreach (rd_cyc[i]) if (rd_cyc[i] >= a) late_rd++;
      foreach (hs_cyc[i]) if (hs_cyc[i] > a) late_hs++;
      vectors++; if (late_rd != 0 || late_hs != 0) begin miscompares++; $display("FAIL abort_quiet got reads %0d words %0d after abort want 0 0", late_rd, late_hs); end
      for (int i = 0; i < hs_addr.size(); i++) begin
         vectors++;
         if (hs_addr[i] !== 8'(8'h40 + i) || hs_data[i] !== data_of(8'(8'h40 + i))) begin
            miscompares++;
            $display("FAIL abort_word%0d got a=%h d=%h want a=%h", i, hs_addr[i], hs_data[i], 8'(8'h40 + i));
         end
      end
      // Fresh command after abort
      clear_logs();
      start_xfer(8'h80, 9'd2, s);
      wait_done(40, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL abort_restart_timeout got none want pulse"); end
      vectors++;
      if (hs_addr.size() != 2 || hs_addr[0] !== 8'h80 || hs_addr[1] !== 8'h81 || hs_data[1] !== data_of(8'h81) ||
          hs_last[0] !== 1'b0 || hs_last[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_restart got n=%0d want 2 words 80,81 last on 81", hs_addr.size());
      end
   endtask

   task automatic test_reset_mid();
      int s, r, late_rd;
      clear_logs(); out_ready = 1'b1;
      start_xfer(8'h20, 9'd16, s);
      repeat (3) @(posedge clk); #1;
      start = 1'b1; base_addr = 8'h90; length = 9'd3;
      @(posedge clk); #1;
      start = 1'b0; rst = 1'b1; r = cyc;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      vectors++;
      if (csb1 !== 1'b1 || addr1 !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 ||
          out_data !== 32'h0 || out_addr !== 8'h00 || out_last !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_outputs got csb1=%b a1=%h busy=%b done=%b v=%b d=%h a=%h l=%b want 1 00 0 0 0 0 00 0",
                  csb1, addr1, busy, done, out_valid, out_data, out_addr, out_last);
      end
      repeat (20) @(posedge clk);
      @(negedge clk); #1;
      late_rd = 0;
      foreach (rd_cyc[i]) if (rd_cyc[i] > r) late_rd++;
      vectors++; if (done_cyc.size() != 0) begin miscompares++; $display("FAIL midreset_no_done got %0d pulses want 0", done_cyc.size()); end
      vectors++; if (late_rd != 0) begin miscompares++; $display("FAIL midreset_reads_after got %0d want 0", late_rd); end
      for (int i = 0; i < rd_addr.size(); i++) begin
         vectors++;
         if (rd_addr[i] !== 8'(8'h20 + i)) begin
            miscompares++;
            $display("FAIL midreset_read%0d got %h want %h", i, rd_addr[i], 8'(8'h20 + i));
         end
      end
      for (int i = 0; i < hs_addr.size(); i++) begin
         vectors++;
         if (hs_addr[i] !== 8'(8'h20 + i)) begin
            miscompares++;
            $display("FAIL midreset_word%0d got %h want %h", i, hs_addr[i], 8'(8'h20 + i));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_zero_len();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sram_port1_reader.md
SRAM_PORT1_READER -- requirements
Module: sram_port1_reader

Interface
REQ-001 Parameter: ADDR_W, default 8, SRAM word-address width (256 words).
REQ-002 Parameter: DATA_W, default 32, SRAM data width.
REQ-003 Ports: one clock; reset is synchronous and active-high; the clock is wb_clk_i and the reset is wb_rst_i.
REQ-004 wb_clk_i  input  1  clock, also drives SRAM clk1.
REQ-005 wb_rst_i  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle command strobe.
REQ-007 base_addr  input  ADDR_W  first word address, sampled with start.
REQ-008 length  input  ADDR_W+1  word count 0..256, sampled with start.
REQ-009 abort  input  1  cancel the active transfer.
REQ-010 busy  output  1  transfer in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 csb1  output  1  SRAM port-1 chip select, active-low.
REQ-013 addr1  output  ADDR_W  SRAM port-1 address.
REQ-014 dout1  input  DATA_W  SRAM port-1 read data.
REQ-015 out_valid  output  1  stream word valid.
REQ-016 out_ready  input  1  stream consumer ready.
REQ-017 out_data  output  DATA_W  stream word.
REQ-018 out_addr  output  ADDR_W  SRAM address of out_data.
REQ-019 out_last  output  1  marks the final word of a transfer.

Function
REQ-020 The block SHALL use a 3-state FSM: IDLE, RUN, DRAIN.
REQ-021 IDLE->RUN SHALL occur on start=1 with length>0, latching base_addr into a read pointer and length into a remaining counter.
REQ-022 A start with length=0 SHALL issue no reads and SHALL pulse done the next cycle, with busy staying 0.
REQ-023 A start seen while busy=1 SHALL be ignored.
REQ-024 SRAM read model: a read issued in cycle N (csb1=0, addr1=A) SHALL have dout1 captured at the end of cycle N+1.
REQ-025 Returned words SHALL be buffered in a 2-entry FIFO that holds data and address.
REQ-026 A read SHALL be issued in a cycle only when remaining>0 and (fifo_occupancy + inflight - pop_this_cycle) < 2.
REQ-027 When no read is issued, csb1 SHALL be 1.
REQ-028 With out_ready held at 1, the block SHALL sustain 1 word per cycle.
REQ-029 The read pointer SHALL increment by 1 per issued read and wrap 255->0 (modulo 2^ADDR_W).
REQ-030 When remaining reaches 0, the FSM SHALL move RUN->DRAIN.
REQ-031 out_last SHALL be 1 exactly on the word whose address is base_addr+length-1 (mod 2^ADDR_W).
REQ-032 The stream handshake SHALL complete on out_valid&&out_ready.
REQ-033 out_data, out_addr and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-034 The completion cycle is the cycle after the out_last handshake: done SHALL be 1 and busy SHALL be 0 in that cycle, and the FSM SHALL return to IDLE.
REQ-035 busy SHALL be 1 in RUN and in DRAIN.
REQ-036 abort while busy SHALL stop reads at once (csb1=1 in the abort cycle), flush the FIFO, and discard the in-flight word.
REQ-037 In the cycle after an abort, out_valid SHALL be 0, done SHALL be 1, busy SHALL be 0 and the FSM SHALL be in IDLE.
REQ-038 abort in IDLE SHALL have no effect.
REQ-039 If start and abort are both 1 in the same IDLE cycle, start SHALL win.
REQ-040 The block SHALL never issue more than length reads per transfer.

Reset
REQ-041 While wb_rst_i=1 at a clock edge, the following SHALL hold: csb1=1, addr1=0, busy=0, done=0, out_valid=0, out_data=0, out_addr=0, out_last=0, FSM=IDLE, FIFO empty, inflight=0.
REQ-042 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse; outputs take the REQ-041 values at the next edge.

Verification
REQ-043 base=0x10, len=4, out_ready=1: the bench SHALL see csb1 low for 4 consecutive cycles at addr 0x10..0x13, out_valid for 4 consecutive cycles, out_last on 0x13, and done 1 cycle later.
REQ-044 base=0xFE, len=4: the bench SHALL see addresses 0xFE, 0xFF, 0x00, 0x01 in order, with out_last on 0x01.
REQ-045 len=8 with out_ready=0 for 10 cycles, then 1: the bench SHALL see exactly 2 reads issued before the stall, no data lost or duplicated, and all 8 words in address order.
REQ-046 len=0: the bench SHALL see a done pulse the next cycle, no csb1 activity, and busy=0 throughout.
REQ-047 Abort after the 3rd word of len=16: the bench SHALL see csb1=1 in the abort cycle, out_valid=0 and done=1 the next cycle, and a fresh start accepted afterwards.
REQ-048 wb_rst_i asserted mid-transfer with start pulsed during busy: the bench SHALL see all outputs at REQ-041 values next cycle, no done pulse, and the start during busy ignored.
